// File: rtl/sd_spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sd_spi_pkg                                             |
// | Description : Shared types and constants for the SD-card SPI engine  |
// |               (state encoding, frame sizes, SCK divider mapping).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_CMD = 2'd1,
    SHIFT_RSP = 2'd2,
    FINISH    = 2'd3
  } state_t;

  localparam int CMD_BITS  = 48;
  localparam int RSP_BITS  = 80;
  localparam int BIT_CNT_W = 7;

  // Terminal count of the SCK half-period counter, i.e. H-1 with
  // H = 2^(div+1) system clocks.
  function automatic logic [3:0] half_period_tc(input logic [1:0] div);
    logic [3:0] tc;
    case (div)
      2'b00:   tc = 4'd1;
      2'b01:   tc = 4'd3;
      2'b10:   tc = 4'd7;
      default: tc = 4'd15;
    endcase
    return tc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_spi_clkgen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sd_spi_clkgen                                          |
// | Description : SPI mode-0 SCK generator. Toggles SCK every H clocks   |
// |               and flags the clock edge on which SCK rises or falls.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sd_spi_clkgen
  import sd_spi_pkg::*;
(
  input  logic       control_clk_i,
  input  logic       control_rst_i,
  input  logic       clear_i,
  input  logic [1:0] div_i,
  output logic       sck_o,
  output logic       rise_o,
  output logic       fall_o
);

  logic [3:0] r_cnt;
  logic       r_sck;
  logic       w_tc;

  assign w_tc   = (r_cnt == half_period_tc(div_i));
  // Strobes are high in the cycle whose closing edge moves SCK.
  assign rise_o = w_tc & ~r_sck & ~clear_i;
  assign fall_o = w_tc &  r_sck & ~clear_i;
  assign sck_o  = r_sck;

  // Half-period counter and SCK toggle; cleared whenever no frame runs.
  always_ff @(posedge control_clk_i or posedge control_rst_i) begin
    if (control_rst_i) begin
      r_cnt <= 4'd0;
      r_sck <= 1'b0;
    end else if (clear_i) begin
      r_cnt <= 4'd0;
      r_sck <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= 4'd0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_spi_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sd_spi_engine                                          |
// | Description : SD-card SPI frame engine: sends a 48-bit command, then |
// |               clocks in an 80-bit response with MOSI held high.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sd_spi_engine
  import sd_spi_pkg::*;
(
  input  logic                control_clk_i,
  input  logic                control_rst_i,
  input  logic                spi_rst_ni,
  input  logic                spi_start_ni,
  input  logic                spi_fbo_i,
  input  logic [1:0]          clock_divider_i,
  input  logic [CMD_BITS-1:0] instruction_i,
  input  logic                miso_i,
  output logic                sck_o,
  output logic                mosi_o,
  output logic                cs_n_o,
  output logic [RSP_BITS-1:0] rx_data_o,
  output logic                done_o,
  output logic                busy_o
);

  localparam logic [BIT_CNT_W-1:0] C_LAST_CMD_BIT = BIT_CNT_W'(CMD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] C_LAST_BIT     = BIT_CNT_W'(CMD_BITS + RSP_BITS - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CMD_BITS-1:0]    r_cmd;
  logic [RSP_BITS-1:0]    r_rsp;
  logic [RSP_BITS-1:0]    r_rx;
  logic [1:0]             r_div;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [CMD_BITS-1:0]    w_cmd_rev;
  logic [CMD_BITS-1:0]    w_cmd_ordered;
  logic                   w_abort;
  logic                   w_clk_clear;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_active;

  assign w_abort     = ~spi_rst_ni;
  assign w_clk_clear = w_abort | (r_state == IDLE);
  assign w_active    = (r_state == SHIFT_CMD) | (r_state == SHIFT_RSP);

  // The command register always shifts out of its MSB, so LSB-first
  // frames are loaded bit-reversed.
  genvar gi;
  generate
    for (gi = 0; gi < CMD_BITS; gi++) begin : g_cmd_rev
      assign w_cmd_rev[gi] = instruction_i[CMD_BITS-1-gi];
    end
  endgenerate
  assign w_cmd_ordered = spi_fbo_i ? instruction_i : w_cmd_rev;

  sd_spi_clkgen u_clkgen (
    .control_clk_i (control_clk_i),
    .control_rst_i (control_rst_i),
    .clear_i       (w_clk_clear),
    .div_i         (r_div),
    .sck_o         (sck_o),
    .rise_o        (w_rise),
    .fall_o        (w_fall)
  );

  // State register.
  always_ff @(posedge control_clk_i or posedge control_rst_i) begin
    if (control_rst_i) r_state <= IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next-state logic; a soft abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (!spi_start_ni) w_state_nxt = SHIFT_CMD;
      SHIFT_CMD: if (w_fall && (r_bit_cnt == C_LAST_CMD_BIT)) w_state_nxt = SHIFT_RSP;
      SHIFT_RSP: if (w_fall && (r_bit_cnt == C_LAST_BIT)) w_state_nxt = FINISH;
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  // Datapath: latch frame inputs at start, shift command on SCK falls,
  // sample MISO on SCK rises, publish the response on the final fall.
  always_ff @(posedge control_clk_i or posedge control_rst_i) begin
    if (control_rst_i) begin
      r_cmd     <= '0;
      r_rsp     <= '0;
      r_rx      <= '0;
      r_div     <= 2'b00;
      r_bit_cnt <= '0;
    end else if (w_abort) begin
      r_bit_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (!spi_start_ni) begin
        r_cmd     <= w_cmd_ordered;
        r_div     <= clock_divider_i;
        r_rsp     <= '0;
        r_bit_cnt <= '0;
      end
    end else if (w_active) begin
      if (w_rise && (r_state == SHIFT_RSP)) begin
        r_rsp <= {r_rsp[RSP_BITS-2:0], miso_i};
      end
      if (w_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_cmd     <= {r_cmd[CMD_BITS-2:0], 1'b1};
        if (r_bit_cnt == C_LAST_BIT) r_rx <= r_rsp;
      end
    end
  end

  assign cs_n_o    = ~w_active;
  assign busy_o    = w_active;
  assign done_o    = (r_state == FINISH);
  assign mosi_o    = (r_state == SHIFT_CMD) ? r_cmd[CMD_BITS-1] : 1'b1;
  assign rx_data_o = r_rx;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sd_spi_engine                                       |
// | Description : Scoreboard bench for sd_spi_engine with an SD-card     |
// |               MISO model and a wire-level MOSI/SCK monitor.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sd_spi_engine;

  logic        control_clk_i = 1'b0;
  logic        control_rst_i = 1'b0;
  logic        spi_rst_ni    = 1'b1;
  logic        spi_start_ni  = 1'b1;
  logic        spi_fbo_i     = 1'b1;
  logic [1:0]  clock_divider_i = 2'b00;
  logic [47:0] instruction_i = '0;
  logic        miso_i = 1'b1;
  logic        sck_o, mosi_o, cs_n_o, done_o, busy_o;
  logic [79:0] rx_data_o;

  sd_spi_engine dut (
    .control_clk_i   (control_clk_i),
    .control_rst_i   (control_rst_i),
    .spi_rst_ni      (spi_rst_ni),
    .spi_start_ni    (spi_start_ni),
    .spi_fbo_i       (spi_fbo_i),
    .clock_divider_i (clock_divider_i),
    .instruction_i   (instruction_i),
    .miso_i          (miso_i),
    .sck_o           (sck_o),
    .mosi_o          (mosi_o),
    .cs_n_o          (cs_n_o),
    .rx_data_o       (rx_data_o),
    .done_o          (done_o),
    .busy_o          (busy_o)
  );

  always #5 control_clk_i = ~control_clk_i;

  typedef struct {
    logic [79:0] rx;
    int          lat;
    logic [47:0] wire_cmd;
    int          period;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [79:0] rsp_pat = '1;

  always @(posedge control_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [79:0] rx, input int lat, input logic [47:0] wc,
                              input int period, input int busy);
    exp_t e;
    e.rx = rx; e.lat = lat; e.wire_cmd = wc; e.period = period; e.busy = busy;
    return e;
  endfunction

  // Card model + monitor, all sampled mid-cycle on the falling clock edge.
  int          rise_cnt = 0, fall_cnt = 0, busy_cnt = 0;
  int          start_cyc = 0, rise0_cyc = 0, rise1_cyc = 0;
  logic        prev_sck = 1'b0, prev_busy = 1'b0;
  logic [47:0] cap = '0;

  always @(negedge control_clk_i) begin
    if (cs_n_o) begin
      rise_cnt = 0;
      fall_cnt = 0;
    end else begin
      if (!prev_sck && sck_o) begin
        if (rise_cnt < 48) cap[47-rise_cnt] = mosi_o;
        if (rise_cnt == 0) rise0_cyc = cyc;
        if (rise_cnt == 1) rise1_cyc = cyc;
        rise_cnt++;
      end
      if (prev_sck && !sck_o) fall_cnt++;
    end
    // Response bit k (0 = first) is presented before SCK rise 48+k.
    miso_i   = (fall_cnt >= 48 && fall_cnt < 128) ? rsp_pat[127-fall_cnt] : 1'b1;
    prev_sck = sck_o;
    if (busy_o && !prev_busy) begin
      start_cyc = cyc;
      busy_cnt  = 0;
    end
    if (busy_o) busy_cnt++;
    prev_busy = busy_o;
    if (done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_data",  rx_data_o,                mon_e.rx);
        chk("latency",  cyc - start_cyc + 1,      mon_e.lat);
        chk("mosi_cmd", cap,                      mon_e.wire_cmd);
        chk("sck_per",  rise1_cyc - rise0_cyc,    mon_e.period);
        chk("busy_len", busy_cnt,                 mon_e.busy);
      end
    end
  end

  task automatic start_frame(input logic [47:0] ins, input logic fbo, input logic [1:0] div,
                             input logic [79:0] pat);
    bit seen = 0;
    @(negedge control_clk_i);
    instruction_i   = ins;
    spi_fbo_i       = fbo;
    clock_divider_i = div;
    rsp_pat         = pat;
    spi_start_ni    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge control_clk_i);
      if (busy_o) seen = 1;
    end
    spi_start_ni = 1'b1;
    if (!seen) chk("start_timeout", 0, 1);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge control_clk_i);
      if (done_o) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic psck;
    int   rises;

    // Asynchronous reset values, checked before any clock edge.
    #1 control_rst_i = 1'b1;
    #1;
    chk("rst_sck",  sck_o,     0);
    chk("rst_mosi", mosi_o,    1);
    chk("rst_csn",  cs_n_o,    1);
    chk("rst_done", done_o,    0);
    chk("rst_busy", busy_o,    0);
    chk("rst_rx",   rx_data_o, 0);
    repeat (3) @(negedge control_clk_i);
    control_rst_i = 1'b0;
    repeat (2) @(negedge control_clk_i);

    // CMD0, MSB first, H=2.
    sb.push_back(mk(80'h01FFFFFFFFFFFFFFFFFF, 513, 48'h400000000095, 4, 512));
    start_frame(48'h400000000095, 1'b1, 2'b00, 80'h01FFFFFFFFFFFFFFFFFF);
    wait_done(600);

    // CMD8, LSB first; a start pulse and new inputs mid-frame must be ignored.
    sb.push_back(mk(80'h01000001AAFFFFFFFFFF, 513, 48'hE15580000012, 4, 512));
    start_frame(48'h48000001AA87, 1'b0, 2'b00, 80'h01000001AAFFFFFFFFFF);
    repeat (98) @(negedge control_clk_i);
    spi_start_ni    = 1'b0;
    instruction_i   = 48'hFFFF_FFFF_FFFF;
    spi_fbo_i       = 1'b1;
    clock_divider_i = 2'b11;
    @(negedge control_clk_i);
    spi_start_ni = 1'b1;
    wait_done(600);
    repeat (30) @(negedge control_clk_i);

    // Slowest divider, H=16.
    sb.push_back(mk(80'h0123456789ABCDEF0123, 4097, 48'h7A0000000001, 32, 4096));
    start_frame(48'h7A0000000001, 1'b1, 2'b11, 80'h0123456789ABCDEF0123);
    wait_done(4200);

    // Soft abort after the 20th SCK rise, H=4.
    start_frame(48'h5100000200FF, 1'b1, 2'b01, 80'hFFFFFFFFFFFFFFFFFFFF);
    psck  = sck_o;
    rises = 0;
    for (int i = 0; i < 400 && rises < 20; i++) begin
      @(negedge control_clk_i);
      if (!psck && sck_o) rises++;
      psck = sck_o;
    end
    chk("abort_rises", rises, 20);
    spi_rst_ni = 1'b0;
    @(negedge control_clk_i);
    chk("abort_csn",  cs_n_o,    1);
    chk("abort_sck",  sck_o,     0);
    chk("abort_busy", busy_o,    0);
    chk("abort_mosi", mosi_o,    1);
    chk("abort_done", done_o,    0);
    chk("abort_rx",   rx_data_o, 80'h0123456789ABCDEF0123);
    spi_rst_ni = 1'b1;

    // Abort and start together: no frame.
    @(negedge control_clk_i);
    spi_rst_ni   = 1'b0;
    spi_start_ni = 1'b0;
    @(negedge control_clk_i);
    chk("both_busy", busy_o, 0);
    chk("both_csn",  cs_n_o, 1);
    spi_rst_ni   = 1'b1;
    spi_start_ni = 1'b1;
    @(negedge control_clk_i);
    chk("both_busy2", busy_o, 0);

    // Full frame after the abort, H=4.
    sb.push_back(mk(80'h00FE5A5A5A5A5A5A5A5A, 1025, 48'h5100000200FF, 8, 1024));
    start_frame(48'h5100000200FF, 1'b1, 2'b01, 80'h00FE5A5A5A5A5A5A5A5A);
    wait_done(1200);

    // Hard reset during the response phase.
    start_frame(48'h400000000095, 1'b1, 2'b00, 80'h0F0F0F0F0F0F0F0F0F0F);
    repeat (298) @(negedge control_clk_i);
    chk("pre_rst_busy", busy_o, 1);
    control_rst_i = 1'b1;
    #1;
    chk("arst_sck",  sck_o,     0);
    chk("arst_mosi", mosi_o,    1);
    chk("arst_csn",  cs_n_o,    1);
    chk("arst_done", done_o,    0);
    chk("arst_busy", busy_o,    0);
    chk("arst_rx",   rx_data_o, 0);
    @(negedge control_clk_i);
    control_rst_i = 1'b0;
    repeat (20) @(negedge control_clk_i);
    chk("post_rst_busy", busy_o, 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_spi_engine.md
SD_SPI_ENGINE -- requirements
Module: sd_spi_engine

Interface
REQ-001 control_clk_i  in  1  system clock; all logic on rising edge.
REQ-002 control_rst_i  in  1  reset, asynchronous, active-high.
REQ-003 spi_rst_ni  in  1  synchronous soft abort, active-low.
REQ-004 spi_start_ni  in  1  frame request, active-low level, sampled only in IDLE.
REQ-005 spi_fbo_i  in  1  command bit order: 1 = MSB first, 0 = LSB first.
REQ-006 clock_divider_i  in  2  SCK half-period select: H = 2^(div+1) clocks, so 00->2, 01->4, 10->8, 11->16.
REQ-007 instruction_i  in  48  SD command frame to transmit.
REQ-008 miso_i  in  1  card data out; assumed pre-synchronised.
REQ-009 sck_o  out  1  SPI clock, mode 0, idle low.
REQ-010 mosi_o  out  1  SPI data to card, idle high.
REQ-011 cs_n_o  out  1  card select, active-low.
REQ-012 rx_data_o  out  80  response bits; [79] is the first bit received.
REQ-013 done_o  out  1  one-cycle frame-complete pulse.
REQ-014 busy_o  out  1  high from frame start until done_o is asserted.

Function
REQ-015 States: IDLE, SHIFT_CMD, SHIFT_RSP, FINISH.
REQ-016 Frame start: IDLE with spi_start_ni=0 and spi_rst_ni=1 at edge N.
- Latch instruction_i, spi_fbo_i and clock_divider_i.
- Next cycle: cs_n_o=0, busy_o=1, mosi_o = first command bit.
REQ-017 SCK: first rising edge H clocks after cs_n_o falls; then alternates every H clocks; 50% duty cycle.
REQ-018 MOSI timing: changes only on SCK falling edges; MISO is sampled on SCK rising edges.
REQ-019 SHIFT_CMD: 48 SCK cycles.
- Command order follows the latched fbo: MSB first sends [47] first; LSB first sends [0] first.
REQ-020 SHIFT_RSP: 80 SCK cycles with mosi_o=1.
- Each sampled bit shifts into an internal register from the LSB end, so the first bit lands in [79].
- Response order is independent of fbo.
REQ-021 FINISH: entered H clocks after the 128th rising edge, with sck_o already low. In that cycle:
- cs_n_o=1;
- done_o=1 for exactly one cycle;
- rx_data_o updated from the shift register;
- return to IDLE.
REQ-022 Latency: done_o asserts exactly 256*H+1 cycles after start edge N.
REQ-023 rx_data_o changes only in FINISH and holds its value between frames.
REQ-024 spi_start_ni is ignored outside IDLE; a start held low re-triggers one cycle after FINISH.
REQ-025 spi_rst_ni=0 in any state, at the next edge:
- IDLE; sck_o=0, cs_n_o=1, mosi_o=1, busy_o=0;
- no done_o pulse; rx_data_o unchanged.
REQ-026 Simultaneous spi_rst_ni=0 and spi_start_ni=0: the abort wins; no frame starts.
REQ-027 Input changes mid-frame (instruction_i, spi_fbo_i, clock_divider_i) have no effect until the next start.

Reset
REQ-028 control_rst_i=1 immediately forces:
- state IDLE;
- sck_o=0, mosi_o=1, cs_n_o=1, done_o=0, busy_o=0;
- rx_data_o=80'h0; all counters and shift registers cleared.
REQ-029 Assertion mid-frame aborts it without a done_o pulse; operation resumes on the first edge after release.

Structure
REQ-030 Package sd_spi_pkg shall hold:
- state encoding;
- CMD_BITS=48, RSP_BITS=80;
- divider-to-H mapping.
REQ-031 Sub-module sd_spi_clkgen shall generate sck_o and single-cycle rise/fall strobes from the latched divider.
- It is cleared by control_rst_i, abort, or IDLE.
REQ-032 Bit counter shall be 7 bits (0..127); no other arithmetic.

Verification
REQ-033 CMD0 frame:
- Stimulus: instruction 48'h400000000095, fbo=1, div=00; MISO model returns 8'h01 followed by 72 ones.
- Response: MOSI bytes 40 00 00 00 00 95; rx_data_o = {8'h01, 72'hFF..FF}; done_o at cycle 513.
REQ-034 LSB-first CMD8:
- Stimulus: instruction 48'h48000001AA87, fbo=0.
- Response: first MOSI byte on wire is E1 (reversed 87); last byte is 12.
REQ-035 Slowest divider:
- Stimulus: div=11, start.
- Response: SCK period 32 clocks; done_o at cycle 4097; busy_o high for 4096 cycles.
REQ-036 Soft abort:
- Stimulus: spi_rst_ni=0 after the 20th SCK rising edge.
- Response: next edge gives cs_n_o=1, sck_o=0, no done_o; rx_data_o keeps its prior value; the next start produces a full correct frame.
REQ-037 Start while busy:
- Stimulus: pulse spi_start_ni low at cycle 100 of a frame.
- Response: ignored; exactly one done_o pulse.
REQ-038 Async reset mid-response:
- Stimulus: assert control_rst_i at cycle 300.
- Response: outputs take reset values immediately; rx_data_o=0.
